updown_counter_arbiter: RTL and testbench
=========================================

# updown_counter_arbiter

Round-robin arbiter and sequencer that shares one N-bit up/down counter among NREQ requesters. Each requester asks for a single increment or decrement. The block grants one requester at a time and applies that step to the internal counter register. It exposes the count, limit flags and a boundary event. It sits in front of the existing N-bit up/down counter datapath, replacing ad-hoc direct control of `up_down`, so multiple agents can share one count safely.

## Interface
- `N`, 3, counter width in bits (≥2)
- `NREQ`, 4, number of requesters (≥2); pointer width is clog2(NREQ)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester step request; level, held until granted
- `dir`  in  NREQ  per-requester direction: 1 = up, 0 = down; sampled with the grant decision
- `clr`  in  1  synchronous clear of count, active-high
- `gnt`  out  NREQ  one-hot grant, one-cycle pulse
- `count`  out  N  current counter value
- `busy`  out  1  high in GRANT and RELEASE states
- `at_max`  out  1  combinational, count == 2^N−1
- `at_min`  out  1  combinational, count == 0
- `limit`  out  1  one-cycle pulse when a step crosses or hits a bound (see Configuration)

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- IDLE with `req` == 0: stay in IDLE.
- IDLE with `req` != 0:
  - Winner w = first set bit at or after `ptr`, searching upward and wrapping.
  - Register `gnt` <= onehot(w) and `step_dir` <= `dir[w]`, then go to GRANT.
- GRANT:
  - `count` <= `count` ±1 per `step_dir`.
  - `gnt` <= 0, `ptr` <= (w+1) mod NREQ, then go to RELEASE.
- RELEASE: no grant is issued; always go to IDLE. This cycle lets the granted requester drop `req` before the next arbitration.
- A requester that keeps `req` high after its grant is treated as a new request. It competes again at lowest round-robin priority.
- `clr` high at an edge forces `count` <= 0 and overrides any step at that edge. The FSM, `gnt` and `ptr` sequencing are unaffected. `limit` does not pulse for a clear.
- Arithmetic is modulo 2^N unless SATURATE_EN is defined. `dir` of non-winners is ignored.

## Timing
- Reset (`reset` = 0): `count` = 0, `gnt` = 0, `busy` = 0, `limit` = 0, `ptr` = 0, state = IDLE. All take effect immediately, without waiting for a clock edge.
- Reset asserted mid-GRANT: the pending step is lost and `gnt` drops immediately.
- Edge E0: a request is seen in IDLE.
- Cycle E0–E1: `gnt` is high and `busy` = 1.
- Edge E1: `count` takes its new value and `limit` pulses if applicable, both for cycle E1–E2.
- Edge E2: back to IDLE. The earliest next `gnt` is at E3.
- Throughput: one step per 3 cycles. Request-to-grant latency is 1 cycle with no contention. Worst case is 3·NREQ cycles.
- `req` changing during GRANT/RELEASE has no effect until the next IDLE sample.

## Configuration
- `UPDOWN_ARB_SATURATE_EN` defined:
  - An up step at 2^N−1 leaves `count` at 2^N−1.
  - A down step at 0 leaves `count` at 0.
  - `limit` pulses on each such blocked step.
  - The grant is still issued and consumed.
- Not defined:
  - Steps wrap: 2^N−1 +1 → 0 and 0 −1 → 2^N−1.
  - `limit` pulses on each wrap.

## Test plan
All scenarios use N=3, NREQ=4.

- **Reset:** `reset`=0 → `count`=000, `gnt`=0000, `busy`=0, `limit`=0. After release with `req`=0, state stays IDLE, `busy`=0.
- **Single requester:** `req[0]`=1, `dir[0]`=1 held for 9 cycles → `gnt[0]` pulses at cycles 1, 4, 7. `count` goes 001, 010, 011, each visible one cycle after its `gnt`.
- **Round-robin:** `req`=1111, `dir`=1111 held → grant order 0, 1, 2, 3, 0 at 3-cycle spacing; `count` increments on each grant.
- **Wrap (macro undefined):**
  - `count`=111, up step → `count`=000, `limit` one-cycle pulse.
  - `count`=000, down step → `count`=111, `limit` pulse.
- **Saturate (`UPDOWN_ARB_SATURATE_EN`):**
  - `count`=111, up step → stays 111, `limit` pulse, `gnt` still issued.
  - `count`=000, down step → stays 000, `limit` pulse.
- **Clear and mid-operation reset:**
  - `clr`=1 at the GRANT-ending edge of an up step from `count`=101 → `count`=000, no `limit` pulse.
  - `reset`=0 during GRANT → `gnt`=0000 and `count`=000 immediately; the first grant after release goes to the lowest-index active requester (`ptr`=0).

Source files
------------

// File: rtl/updown_counter_arbiter.sv
// rtl/updown_counter_arbiter.sv - round-robin arbiter sharing one N-bit up/down counter among NREQ requesters
// Optional feature macro: UPDOWN_ARB_SATURATE_EN (saturate at the bounds instead of wrapping).
module updown_counter_arbiter #(
  parameter int N    = 3,
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] dir,
  input  logic            clr,
  output logic [NREQ-1:0] gnt,
  output logic [N-1:0]    count,
  output logic            busy,
  output logic            at_max,
  output logic            at_min,
  output logic            limit
);

  localparam int               PW       = $clog2(NREQ);
  localparam logic [N-1:0]     CNT_MAX  = '1;
  localparam logic [N-1:0]     CNT_ONE  = N'(1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]    LAST_REQ = PW'(NREQ - 1);
  localparam logic [PW:0]      NREQ_W   = (PW + 1)'(NREQ);
  localparam logic [NREQ-1:0]  ONEHOT0  = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            step_dir_q, step_dir_d;
  logic [N-1:0]    count_q, count_d;
  logic            limit_q, limit_d;

  logic [NREQ-1:0] rot;
  logic [PW:0]     sum;
  logic            found;
  logic [PW-1:0]   pick;

  // Round-robin search: rotate req so ptr sits at bit 0, take the first set bit, map back
  always_comb begin
    rot   = NREQ'({req, req} >> ptr_q);
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_q} + (PW + 1)'(i);
        if (sum >= NREQ_W) begin
          sum = sum - NREQ_W;
        end
        pick  = sum[PW-1:0];
      end
    end
  end

  // State, pointer, grant and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      gnt_q      <= '0;
      step_dir_q <= 1'b0;
      count_q    <= '0;
      limit_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      step_dir_q <= step_dir_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
    end
  end

  // Next-state: arbitrate in IDLE, apply the step in GRANT, one dead cycle in RELEASE
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    step_dir_d = step_dir_q;
    count_d    = count_q;
    limit_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d      = pick;
          gnt_d      = ONEHOT0 << pick;
          step_dir_d = dir[pick];
          state_d    = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt_d   = '0;
        ptr_d   = (win_q == LAST_REQ) ? '0 : win_q + PTR_ONE;
        state_d = S_RELEASE;
        if (step_dir_q) begin
          if (count_q == CNT_MAX) begin
            limit_d = 1'b1;
`ifdef UPDOWN_ARB_SATURATE_EN
            count_d = CNT_MAX;
`else
            count_d = '0;
`endif
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          if (count_q == '0) begin
            limit_d = 1'b1;
`ifdef UPDOWN_ARB_SATURATE_EN
            count_d = '0;
`else
            count_d = CNT_MAX;
`endif
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Clear wins over any step and never reports a boundary event
    if (clr) begin
      count_d = '0;
      limit_d = 1'b0;
    end
  end

  assign gnt    = gnt_q;
  assign count  = count_q;
  assign limit  = limit_q;
  assign busy   = (state_q != S_IDLE);
  assign at_max = (count_q == CNT_MAX);
  assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_arbiter.sv
// tb/tb_updown_counter_arbiter.sv - self-checking bench for updown_counter_arbiter with a behavioural model
module tb_updown_counter_arbiter;

  localparam int N    = 3;
  localparam int NREQ = 4;
  localparam int MAXV = (1 << N) - 1;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] dir;
  logic            clr;
  logic [NREQ-1:0] gnt;
  logic [N-1:0]    count;
  logic            busy;
  logic            at_max;
  logic            at_min;
  logic            limit;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Behavioural model: phase 0 = free to arbitrate, 1 = step pending, 2 = dead cycle
  int              m_count;
  int              m_ptr;
  int              m_win;
  int              m_phase;
  logic [NREQ-1:0] m_gnt;
  bit              m_dir;
  bit              m_limit;

  updown_counter_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .dir    (dir),
    .clr    (clr),
    .gnt    (gnt),
    .count  (count),
    .busy   (busy),
    .at_max (at_max),
    .at_min (at_min),
    .limit  (limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ptr   = 0;
    m_win   = 0;
    m_phase = 0;
    m_gnt   = '0;
    m_dir   = 0;
    m_limit = 0;
  endtask

  task automatic model_step();
    int  newc;
    bit  lim;
    bit  found;
    int  k;
    newc  = m_count;
    lim   = 0;
    found = 0;
    case (m_phase)
      0: begin
        m_gnt = '0;
        if (req != '0) begin
          for (int i = 0; i < NREQ; i++) begin
            k = (m_ptr + i) % NREQ;
            if (!found && req[k]) begin
              found = 1;
              m_win = k;
            end
          end
          m_gnt   = NREQ'(1 << m_win);
          m_dir   = dir[m_win];
          m_phase = 1;
        end
      end
      1: begin
        newc = m_dir ? m_count + 1 : m_count - 1;
        if (newc > MAXV || newc < 0) begin
          lim = 1;
`ifdef UPDOWN_ARB_SATURATE_EN
          newc = m_count;
`else
          newc = (newc + MAXV + 1) % (MAXV + 1);
`endif
        end
        m_gnt   = '0;
        m_ptr   = (m_win + 1) % NREQ;
        m_phase = 2;
      end
      default: begin
        m_phase = 0;
      end
    endcase
    if (clr) begin
      newc = 0;
      lim  = 0;
    end
    m_count = newc;
    m_limit = lim;
  endtask

  // Advance one clock: model follows the edge, caller resumes 1 time unit later
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  // Asynchronous reset with immediate checks, released away from the clock edge
  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_count", count, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_limit", limit, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One isolated step by requester id; checks the grant, the resulting count and limit
  task automatic one_step(input int id, input bit d, input bit c, input int exp_cnt, input bit exp_lim);
    req     = '0;
    dir     = '0;
    req[id] = 1'b1;
    dir[id] = d;
    tick();
    chk("step_gnt", gnt, 1 << id);
    req = '0;
    clr = c;
    tick();
    chk("step_count", count, exp_cnt);
    chk("step_limit", limit, exp_lim);
    clr = 1'b0;
    tick();
    chk("step_idle", busy, 0);
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("model_gnt", gnt, m_gnt);
      chk("model_count", count, m_count);
      chk("model_busy", busy, (m_phase != 0) ? 1 : 0);
      chk("model_limit", limit, m_limit);
      chk("model_at_max", at_max, (m_count == MAXV) ? 1 : 0);
      chk("model_at_min", at_min, (m_count == 0) ? 1 : 0);
    end
  end

  initial begin
    int rr_exp [5];
    rr_exp = '{1, 2, 4, 8, 1};
    reset = 1'b0;
    req   = '0;
    dir   = '0;
    clr   = 1'b0;

    apply_reset();
    chk_en = 1;
    tick();
    tick();
    chk("idle_after_reset", busy, 0);

    // Single requester held: grants at cycles 1, 4, 7; count follows one cycle later
    req = 4'b0001;
    dir = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("single_gnt", gnt, (k % 3 == 1) ? 1 : 0);
      chk("single_count", count, (k + 1) / 3);
    end
    req = '0;
    tick();

    // Round-robin with all requesters active
    apply_reset();
    req = 4'b1111;
    dir = 4'b1111;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k % 3 == 1) chk("rr_gnt", gnt, rr_exp[k / 3]);
    end
    req = '0;
    tick();
    chk("rr_count", count, 5);
    tick();

    // Clear at the end of an up step from 5
    apply_reset();
    for (int k = 1; k <= 5; k++) one_step(0, 1'b1, 1'b0, k, 1'b0);
    one_step(0, 1'b1, 1'b1, 0, 1'b0);

    // Lower bound, then upper bound
`ifdef UPDOWN_ARB_SATURATE_EN
    one_step(1, 1'b0, 1'b0, 0, 1'b1);
    for (int k = 1; k <= MAXV; k++) one_step(2, 1'b1, 1'b0, k, 1'b0);
    one_step(3, 1'b1, 1'b0, MAXV, 1'b1);
`else
    one_step(1, 1'b0, 1'b0, MAXV, 1'b1);
    one_step(3, 1'b1, 1'b0, 0, 1'b1);
`endif

    // Reset during GRANT: grant drops at once, pointer returns to 0
    apply_reset();
    req = 4'b0110;
    dir = 4'b0110;
    tick();
    chk("mid_first_gnt", gnt, 4'b0010);
    tick();
    tick();
    tick();
    chk("mid_second_gnt", gnt, 4'b0100);
    #2;
    apply_reset();
    tick();
    chk("mid_after_rst_gnt", gnt, 4'b0010);
    req = '0;
    tick();
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        apply_reset();
      end
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i] && ($urandom_range(0, 1) == 1)) req[i] = 1'b0;
        else if (!req[i] && ($urandom_range(0, 3) == 0)) req[i] = 1'b1;
      end
      dir = NREQ'($urandom);
      clr = ($urandom_range(0, 19) == 0);
    end
    clr = 1'b0;
    req = '0;
    tick();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
